// File: rtl/load_store_unit_if.sv
// Request, response and data_memory signals of the load/store unit.
// The unit uses the slave side; the execute stage plus memory model use the master side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_rnum;
  logic [31:0] mem_wnum;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_rnum, mem_wnum, mem_wdata, mem_write
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_rnum, mem_wnum, mem_wdata, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-only data memory.
// state | meaning
// IDLE  | ready for a request
// LOAD  | read addressed word, capture extended lane data
// RMW   | read addressed word, merge sub-word store data
// STORE | single-cycle memory write
// ERR   | request rejected, flag error
// RESP  | hold response until consumed
module load_store_unit #(
  parameter int SIZE = 64
) (
  input logic              clock,
  input logic              reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW, STORE, ERR, RESP} state_t;

  state_t      state, state_next;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [29:0] idx_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        error_q;

  logic        accept;
  logic        bad;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept = bus.req_valid && (state == IDLE);
  assign bad = (bus.req_size == 2'b11) ||
               ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
               ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00)) ||
               (bus.req_addr[31:2] >= 30'(SIZE));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bad)                         state_next = ERR;
          else if (!bus.req_write)         state_next = LOAD;
          else if (bus.req_size == 2'b10)  state_next = STORE;
          else                             state_next = RMW;
        end
      end
      LOAD:    state_next = RESP;
      RMW:     state_next = STORE;
      STORE:   state_next = RESP;
      ERR:     state_next = RESP;
      RESP:    if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    lane_byte = bus.mem_rdata[{lane_q, 3'b000} +: 8];
    lane_half = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = {{16{signed_q & lane_half[15]}}, lane_half};
      default: load_ext = bus.mem_rdata;
    endcase
    merged = bus.mem_rdata;
    if (size_q == 2'b00) merged[{lane_q, 3'b000} +: 8]   = wdata_q[7:0];
    else                 merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // wdata_q doubles as the memory write data: raw store data, or the merged word after RMW
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      idx_q    <= '0;
      lane_q   <= 2'b00;
      wdata_q  <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      if (accept) begin
        size_q   <= bus.req_size;
        signed_q <= bus.req_signed;
        idx_q    <= bus.req_addr[31:2];
        lane_q   <= bus.req_addr[1:0];
        wdata_q  <= bus.req_wdata;
        rdata_q  <= '0;
        error_q  <= 1'b0;
      end
      if (state == LOAD) rdata_q <= load_ext;
      if (state == RMW)  wdata_q <= merged;
      if (state == ERR) begin
        rdata_q <= '0;
        error_q <= 1'b1;
      end
      if ((state == RESP) && bus.resp_ready) error_q <= 1'b0;
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = error_q;
  assign bus.mem_rnum   = {2'b00, idx_q};
  assign bus.mem_wnum   = {2'b00, idx_q};
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_write  = (state == STORE);

endmodule
